cla_sub_serial: RTL and testbench
=================================

Name: cla_sub_serial

Overview:
- Multi-cycle subtractor that computes D = A - B - Bin, one NIBBLE-wide slice per clock.
- Each slice uses 4-bit borrow-lookahead logic: generate/propagate formed on A and ~B, all slice carries resolved in parallel.
- A registered borrow chains slices across cycles.
- Sits beside the combinational CLA adders as the area-lean subtract/compare unit, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, operand and result width; must be a multiple of NIBBLE.
- NIBBLE, 4, bits processed per cycle. STEPS = WIDTH/NIBBLE.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  (a - b - bin) mod 2^WIDTH.
- bout  output  1  unsigned borrow out; 1 iff a < b + bin (unsigned).
- ovf  output  1  signed overflow; 1 iff signed a - b - bin lies outside the WIDTH-bit two's-complement range.
- zero  output  1  diff == 0.

Behaviour:
- Arithmetic is A + ~B + ~bin. Per-slice carry out c: the next slice's borrow = ~c.
- Final bout = ~carry out of the MSB slice.
- ovf = (carry into MSB) XOR (carry out of MSB).
- States: IDLE, RUN, DONE. Step counter cnt counts 0..STEPS-1.
- in_ready = (state == IDLE), decoded combinationally from state. in_ready is therefore 1 during reset.
- IDLE: in_valid & in_ready at edge T:
  - latch a, b, and ~bin as the initial carry.
  - cnt <= 0; state <= RUN.
- RUN: each edge writes slice cnt of diff and registers that slice's carry out.
  - Edge T+1 writes slice 0; edge T+STEPS writes slice STEPS-1.
  - On edge T+STEPS: bout, ovf and zero are registered, out_valid <= 1, state <= DONE.
  - Latency is STEPS cycles from the accept edge to out_valid high (4 at defaults).
- diff slices not yet written during RUN are don't-care. diff, bout, ovf and zero are only defined while out_valid = 1.
- DONE:
  - diff, bout, ovf, zero and out_valid are held stable until out_valid & out_ready.
  - On that edge: out_valid <= 0, state <= IDLE.
  - A new accept is possible no earlier than the following edge, so throughput is one op per STEPS+2 cycles.
- in_valid is ignored outside IDLE. a, b and bin need only be stable on the accept edge.
- out_ready is ignored outside DONE.
- Reset (rst_n = 0, any state, including mid-RUN):
  - immediately: state = IDLE, cnt = 0, out_valid = 0, diff = 0, bout = 0, ovf = 0, zero = 0, internal carry = 0.
  - the in-flight operation is discarded, with no partial result.
- Wrap-around: results are modulo 2^WIDTH. Only bout and ovf signal out-of-range results.

Test Plan:
- a=0x1234, b=0x0034, bin=0 accepted at edge T -> out_valid rises at T+4; diff=0x1200, bout=0, ovf=0, zero=0.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0, zero=0 (borrow ripples through all 4 slices).
- a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1, zero=0; and a=0x7FFF, b=0xFFFF -> diff=0x8000, bout=1, ovf=1.
- a=0x5555, b=0x5554, bin=1 -> diff=0x0000, zero=1, bout=0, ovf=0.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid -> outputs are unchanged and in_ready=0. A new in_valid pulse is ignored. out_ready=1 -> in_ready=1 on the next cycle, and the next op is accepted and correct.
- Assert rst_n=0 two cycles into RUN -> all outputs are 0 immediately and in_ready=1. After release, a=0x0010, b=0x0001 -> diff=0x000F.

Source files
------------

// File: rtl/cla_sub_serial.sv
// Serial subtractor: D = A - B - Bin computed one NIBBLE-wide slice per clock,
// each slice resolved with borrow-lookahead logic, slices chained by a registered carry.
module cla_sub_serial #(
    parameter int WIDTH  = 16,
    parameter int NIBBLE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);
    localparam int STEPS = WIDTH / NIBBLE;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  nb_reg;
    logic              carry_reg;
    logic [WIDTH-1:0]  diff_reg, diff_next;
    logic              bout_reg, ovf_reg, zero_reg, out_valid_reg;

    logic [NIBBLE-1:0] g, p, s;
    logic [NIBBLE:0]   c;
    logic              accept, last_step;

    assign in_ready  = (state_reg == IDLE);
    assign accept    = in_valid && in_ready;
    assign last_step = (state_reg == RUN) && (cnt_reg == CW'(STEPS - 1));

    // Operands shift right each step, so the active slice always sits in the low bits.
    assign g    = a_reg[NIBBLE-1:0] & nb_reg[NIBBLE-1:0];
    assign p    = a_reg[NIBBLE-1:0] ^ nb_reg[NIBBLE-1:0];
    assign c[0] = carry_reg;

    // Every slice carry is a flat sum of products of g, p and the incoming carry.
    for (genvar gi = 0; gi < NIBBLE; gi++) begin : g_cla
        logic c_la;
        always_comb begin
            logic prod;
            c_la = carry_reg & (&p[gi:0]);
            for (int j = 0; j <= gi; j++) begin
                prod = g[j];
                for (int k = j + 1; k <= gi; k++) begin
                    prod = prod & p[k];
                end
                c_la = c_la | prod;
            end
        end
        assign c[gi+1] = c_la;
        assign s[gi]   = p[gi] ^ c[gi];
    end

    always_comb begin
        diff_next = diff_reg;
        for (int i = 0; i < STEPS; i++) begin
            if (cnt_reg == CW'(i)) begin
                diff_next[i*NIBBLE +: NIBBLE] = s;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg       <= '0;
            a_reg         <= '0;
            nb_reg        <= '0;
            carry_reg     <= 1'b0;
            diff_reg      <= '0;
            bout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            zero_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            if (accept) begin
                a_reg     <= a;
                nb_reg    <= ~b;
                carry_reg <= ~bin;
                cnt_reg   <= '0;
            end else if (state_reg == RUN) begin
                diff_reg  <= diff_next;
                carry_reg <= c[NIBBLE];
                a_reg     <= a_reg >> NIBBLE;
                nb_reg    <= nb_reg >> NIBBLE;
                cnt_reg   <= cnt_reg + 1'b1;
                if (last_step) begin
                    bout_reg      <= ~c[NIBBLE];
                    ovf_reg       <= c[NIBBLE] ^ c[NIBBLE-1];
                    zero_reg      <= (diff_next == '0);
                    out_valid_reg <= 1'b1;
                end
            end else if (state_reg == DONE && out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign diff      = diff_reg;
    assign bout      = bout_reg;
    assign ovf       = ovf_reg;
    assign zero      = zero_reg;
    assign out_valid = out_valid_reg;
endmodule

// File: tb/tb_cla_sub_serial.sv
// Scoreboard bench for cla_sub_serial: the driver pushes hand-computed results,
// a negedge monitor pops and compares on every output handshake.
module tb_cla_sub_serial;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0, b = '0;
    logic        bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] diff;
    logic        bout, ovf, zero;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rise_cyc = 0;
    logic prev_ov = 1'b0;

    typedef struct {
        logic [15:0] diff;
        logic        bout;
        logic        ovf;
        logic        zero;
        int          acc;
    } exp_t;
    exp_t sb[$];

    cla_sub_serial #(.WIDTH(16), .NIBBLE(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Monitor: compares at each out_valid & out_ready handshake.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid && !prev_ov) rise_cyc = cyc;
        prev_ov = out_valid;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'(diff), 32'hDEAD);
            end else begin
                e = sb.pop_front();
                $display("result diff=%h bout=%b ovf=%b zero=%b (expect %h %b %b %b)",
                         diff, bout, ovf, zero, e.diff, e.bout, e.ovf, e.zero);
                chk("diff", 32'(diff), 32'(e.diff));
                chk("bout", 32'(bout), 32'(e.bout));
                chk("ovf", 32'(ovf), 32'(e.ovf));
                chk("zero", 32'(zero), 32'(e.zero));
                chk("latency", 32'(rise_cyc - e.acc), 32'd4);
            end
        end
    end

    task automatic issue(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin,
                         input logic [15:0] ed, input logic eb, input logic eo, input logic ez,
                         input bit track);
        exp_t e;
        int n = 0;
        @(posedge clk); #1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        a = ta; b = tb_; bin = tbin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (track) begin
            e.diff = ed; e.bout = eb; e.ovf = eo; e.zero = ez; e.acc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        issue(16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0, 1'b0, 1'b1); drain();
        issue(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1); drain();
        issue(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b1); drain();
        issue(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1); drain();
        issue(16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1); drain();
        issue(16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1); drain();

        // Backpressure: result held for 3 cycles, a stray in_valid must be ignored.
        out_ready = 1'b0;
        issue(16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        a = 16'hFFFF; b = 16'h0000; bin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_diff", 32'(diff), 32'h9998);
            chk("bp_hold_flags", {29'd0, bout, ovf, zero}, 32'd0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        issue(16'h0100, 16'h0200, 1'b0, 16'hFF00, 1'b1, 1'b0, 1'b0, 1'b1); drain();

        // Reset two cycles into RUN discards the operation.
        issue(16'h4321, 16'h1111, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_outs", {15'd0, out_valid, diff, bout, ovf, zero}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b1); drain();

        repeat (10) @(posedge clk);
        #1;
        chk("final_queue_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
